conveyor_load_unit: RTL and testbench

- Issues memory reads on behalf of the read instructions and tracks every outstanding request in an in-order queue.
- Writes each returned word, or a fault, into its reserved conveyor slot.
- Sits directly upstream of the conveyor control stage and is the producer of the conveyor's finished/fault/value slot contents for loads.
- Decode supplies the target slot (back1 of the selected conveyor) at issue time; this block owns the memory handshake and completion write.

---
 rtl/conveyor_load_unit_if.sv | 54 +++++
 rtl/conveyor_load_unit.sv | 180 ++++++++++++++++++
 tb/tb_conveyor_load_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conveyor_load_unit_if.sv
// conveyor_load_unit_if: issue, memory and conveyor-write signals of the load unit.
//
// Handshake rule for every valid/ready pair on this interface: a transfer
// happens on a rising clock edge where valid && ready are both high. The
// producer holds valid and its payload until that edge. The consumer may
// change ready freely. mem_resp_valid has no ready: a response is taken in
// every cycle where it is high.
interface conveyor_load_unit_if #(
    parameter int WORD_WIDTH          = 32,
    parameter int CONVEYOR_ADDR_WIDTH = 4,
    parameter int QUEUE_ADDR_WIDTH    = 2,
    parameter int FAULT_ADDR_WIDTH    = 3
);
    // decode -> load unit
    logic                           issue_valid;
    logic                           issue_ready;
    logic [WORD_WIDTH-1:0]          issue_addr;
    logic                           issue_conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0] issue_slot;
    // load unit <-> memory
    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic [WORD_WIDTH-1:0]          mem_req_addr;
    logic                           mem_resp_valid;
    logic [WORD_WIDTH-1:0]          mem_resp_data;
    logic                           mem_resp_error;
    // load unit -> conveyor control
    logic                           cv_write;
    logic                           cv_conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0] cv_slot;
    logic [WORD_WIDTH-1:0]          cv_value;
    logic [FAULT_ADDR_WIDTH-1:0]    cv_fault;
    // status
    logic [QUEUE_ADDR_WIDTH:0]      pending;
    logic                           spurious_resp;

    // load unit side
    modport slave (
        input  issue_valid, issue_addr, issue_conveyor, issue_slot,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error,
        output issue_ready, mem_req_valid, mem_req_addr,
               cv_write, cv_conveyor, cv_slot, cv_value, cv_fault,
               pending, spurious_resp
    );

    // environment side (decode, memory and conveyor together)
    modport master (
        output issue_valid, issue_addr, issue_conveyor, issue_slot,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error,
        input  issue_ready, mem_req_valid, mem_req_addr,
               cv_write, cv_conveyor, cv_slot, cv_value, cv_fault,
               pending, spurious_resp
    );
endinterface

// File: rtl/conveyor_load_unit.sv
// conveyor_load_unit: issues memory reads for loads and keeps every
// outstanding request in an in-order queue of {conveyor, slot}. Each
// response, or a fault, is written into its reserved conveyor slot one
// cycle later.
// Optional feature: define LOAD_TIMEOUT_EN to time out an unanswered head.
// A timed-out head is completed with FAULT_TIMEOUT, and the late response
// that belongs to it is dropped later.
module conveyor_load_unit #(
    parameter int                          WORD_WIDTH          = 32,
    parameter int                          CONVEYOR_ADDR_WIDTH = 4,
    parameter int                          QUEUE_ADDR_WIDTH    = 2,
    parameter int                          FAULT_ADDR_WIDTH    = 3,
    parameter logic [FAULT_ADDR_WIDTH-1:0] FAULT_NONE          = 3'd0,
    parameter logic [FAULT_ADDR_WIDTH-1:0] FAULT_BUS           = 3'd2,
    parameter logic [FAULT_ADDR_WIDTH-1:0] FAULT_TIMEOUT       = 3'd3,
    parameter int                          TIMEOUT_CYCLES      = 64
) (
    input  logic                clk,
    input  logic                reset,
    conveyor_load_unit_if.slave bus
);
    localparam int DEPTH   = 1 << QUEUE_ADDR_WIDTH;
    localparam int ENTRY_W = CONVEYOR_ADDR_WIDTH + 1;

    typedef logic [QUEUE_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [QUEUE_ADDR_WIDTH:0]   cnt_t;

    logic [ENTRY_W-1:0]             r_queue [DEPTH];
    ptr_t                           r_head;
    ptr_t                           r_tail;
    cnt_t                           r_count;
    logic                           r_cv_write;
    logic                           r_cv_conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0] r_cv_slot;
    logic [WORD_WIDTH-1:0]          r_cv_value;
    logic [FAULT_ADDR_WIDTH-1:0]    r_cv_fault;
    logic                           r_spurious;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_resp_pop;
    logic               w_timeout_pop;
    logic               w_pop;
    logic               w_resp_spurious;
    logic [ENTRY_W-1:0] w_head_entry;

    assign w_full       = (r_count == cnt_t'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_head_entry = r_queue[r_head];

    // The request path is purely combinational. A pop in the same cycle
    // does not free space for an issue (no bypass).
    assign bus.mem_req_valid = bus.issue_valid && !w_full;
    assign bus.mem_req_addr  = bus.issue_addr;
    assign bus.issue_ready   = bus.mem_req_ready && !w_full;
    assign w_push            = bus.issue_valid && bus.issue_ready;
    assign w_pop             = w_resp_pop || w_timeout_pop;

`ifdef LOAD_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] r_timer;
    cnt_t               r_drop_count;
    logic               w_dropping;
    logic               w_at_limit;

    // Responses owed to heads that timed out are still in flight. They are
    // consumed first and never complete a newer entry.
    assign w_dropping      = (r_drop_count != '0);
    assign w_at_limit      = (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign w_resp_pop      = bus.mem_resp_valid && !w_dropping && !w_empty;
    assign w_resp_spurious = bus.mem_resp_valid && !w_dropping && w_empty;
    assign w_timeout_pop   = !bus.mem_resp_valid && !w_empty && w_at_limit;

    // Count the cycles the current head waits. Any pop restarts the count.
    // A response that lands in the limit cycle also restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_empty || w_pop || (bus.mem_resp_valid && w_at_limit)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // One late response is owed for every timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_count <= '0;
        end else if (w_timeout_pop) begin
            r_drop_count <= r_drop_count + 1'b1;
        end else if (bus.mem_resp_valid && w_dropping) begin
            r_drop_count <= r_drop_count - 1'b1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_resp_pop      = bus.mem_resp_valid && !w_empty;
    assign w_resp_spurious = bus.mem_resp_valid && w_empty;
    assign w_timeout_pop   = 1'b0;
    assign w_unused_cfg    = ^{FAULT_TIMEOUT, 32'(TIMEOUT_CYCLES)};
`endif

    // Store the target of each accepted load at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_queue[i] <= '0;
            end
        end else if (w_push) begin
            r_queue[r_tail] <= {bus.issue_conveyor, bus.issue_slot};
        end
    end

    // Pointers wrap naturally at DEPTH. The occupancy follows push minus pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Completion write for the popped head, registered one cycle after the
    // response. The cv_* payload holds between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cv_write    <= 1'b0;
            r_cv_conveyor <= 1'b0;
            r_cv_slot     <= '0;
            r_cv_value    <= '0;
            r_cv_fault    <= FAULT_NONE;
        end else begin
            r_cv_write <= w_pop;
            if (w_pop) begin
                r_cv_conveyor <= w_head_entry[ENTRY_W-1];
                r_cv_slot     <= w_head_entry[CONVEYOR_ADDR_WIDTH-1:0];
            end
            if (w_resp_pop) begin
                r_cv_value <= bus.mem_resp_error ? '0 : bus.mem_resp_data;
                r_cv_fault <= bus.mem_resp_error ? FAULT_BUS : FAULT_NONE;
            end else if (w_timeout_pop) begin
                r_cv_value <= '0;
                r_cv_fault <= FAULT_TIMEOUT;
            end
        end
    end

    // Sticky flag: a response arrived that no outstanding load could own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_spurious <= 1'b0;
        end else if (w_resp_spurious) begin
            r_spurious <= 1'b1;
        end
    end

    assign bus.cv_write      = r_cv_write;
    assign bus.cv_conveyor   = r_cv_conveyor;
    assign bus.cv_slot       = r_cv_slot;
    assign bus.cv_value      = r_cv_value;
    assign bus.cv_fault      = r_cv_fault;
    assign bus.pending       = r_count;
    assign bus.spurious_resp = r_spurious;
endmodule

// File: tb/tb_conveyor_load_unit.sv
// tb_conveyor_load_unit: directed test of conveyor_load_unit. The bench keeps
// its own FIFO of issued {conveyor, slot} targets and compares every
// completion write against it.
module tb_conveyor_load_unit;
    localparam int         WW        = 32;
    localparam int         CW        = 4;
    localparam int         QW        = 2;
    localparam int         FW        = 3;
    localparam logic [2:0] F_NONE    = 3'd0;
    localparam logic [2:0] F_BUS     = 3'd2;
    localparam logic [2:0] F_TIMEOUT = 3'd3;

    logic clk;
    logic reset;

    conveyor_load_unit_if #(
        .WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(CW),
        .QUEUE_ADDR_WIDTH(QW), .FAULT_ADDR_WIDTH(FW)
    ) bus ();

    conveyor_load_unit #(
        .WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(CW), .QUEUE_ADDR_WIDTH(QW),
        .FAULT_ADDR_WIDTH(FW), .FAULT_NONE(F_NONE), .FAULT_BUS(F_BUS),
        .FAULT_TIMEOUT(F_TIMEOUT), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [CW:0] exp_q[$];           // {conveyor, slot} in issue order
    int          exp_pending = 0;
    logic        last_conv = 1'b0;   // payload of the last completion write
    logic [3:0]  last_slot = '0;
    logic [31:0] last_val  = '0;
    logic [2:0]  last_fault = F_NONE;

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted load. The bench model pushes the target.
    task automatic issue(input logic [31:0] addr, input logic conv, input logic [3:0] slot);
        bus.issue_valid    = 1'b1;
        bus.issue_addr     = addr;
        bus.issue_conveyor = conv;
        bus.issue_slot     = slot;
        bus.mem_req_ready  = 1'b1;
        #1;
        check("issue_ready", bus.issue_ready, 1);
        check("mem_req_valid", bus.mem_req_valid, 1);
        check("mem_req_addr", bus.mem_req_addr, addr);
        step();
        bus.issue_valid = 1'b0;
        exp_q.push_back({conv, slot});
        exp_pending++;
        check("pending_issue", bus.pending, exp_pending);
    endtask

    // One response cycle. It can also issue a load in the same cycle.
    // The write is checked one cycle later.
    task automatic respond(input logic [31:0] data, input logic err,
                           input bit do_issue, input logic conv, input logic [3:0] slot);
        int          had;
        logic [CW:0] e;
        had                = exp_q.size();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        bus.mem_resp_error = err;
        if (do_issue) begin
            bus.issue_valid    = 1'b1;
            bus.issue_addr     = 32'h0000_0400;
            bus.issue_conveyor = conv;
            bus.issue_slot     = slot;
            bus.mem_req_ready  = 1'b1;
        end
        step();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_error = 1'b0;
        bus.issue_valid    = 1'b0;
        if (had == 0) begin
            check("spurious_no_write", bus.cv_write, 0);
            check("spurious_flag", bus.spurious_resp, 1);
            check("spurious_value_hold", bus.cv_value, last_val);
            check("spurious_slot_hold", bus.cv_slot, last_slot);
        end else begin
            e          = exp_q.pop_front();
            exp_pending--;
            last_conv  = e[CW];
            last_slot  = e[CW-1:0];
            last_val   = err ? 32'h0 : data;
            last_fault = err ? F_BUS : F_NONE;
            check("cv_write", bus.cv_write, 1);
            check("cv_conveyor", bus.cv_conveyor, last_conv);
            check("cv_slot", bus.cv_slot, last_slot);
            check("cv_value", bus.cv_value, last_val);
            check("cv_fault", bus.cv_fault, last_fault);
        end
        if (do_issue) begin
            exp_q.push_back({conv, slot});
            exp_pending++;
        end
        check("pending_resp", bus.pending, exp_pending);
    endtask

    initial begin
        // reset
        reset              = 1'b0;
        bus.issue_valid    = 1'b0;
        bus.issue_addr     = '0;
        bus.issue_conveyor = 1'b0;
        bus.issue_slot     = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_error = 1'b0;
        step();
        step();
        check("rst_pending", bus.pending, 0);
        check("rst_cv_write", bus.cv_write, 0);
        check("rst_cv_conveyor", bus.cv_conveyor, 0);
        check("rst_cv_slot", bus.cv_slot, 0);
        check("rst_cv_value", bus.cv_value, 0);
        check("rst_cv_fault", bus.cv_fault, F_NONE);
        check("rst_spurious", bus.spurious_resp, 0);
        check("rst_issue_ready_mem_busy", bus.issue_ready, 0);
        reset = 1'b1;
        step();

        // single load, response three cycles after the issue
        issue(32'h0000_0100, 1'b0, 4'hF);
        step();
        step();
        check("single_wait_no_write", bus.cv_write, 0);
        respond(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        check("single_write_drops", bus.cv_write, 0);
        check("single_value_hold", bus.cv_value, 32'hDEAD_BEEF);

        // fill the queue, then block further issues
        issue(32'h0000_1000, 1'b0, 4'h1);
        issue(32'h0000_1004, 1'b1, 4'h2);
        issue(32'h0000_1008, 1'b0, 4'h3);
        issue(32'h0000_100C, 1'b1, 4'h4);
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 32'h0000_1010;
        #1;
        check("full_issue_ready", bus.issue_ready, 0);
        check("full_mem_req_valid", bus.mem_req_valid, 0);
        step();
        check("full_pending", bus.pending, 4);
        // a pop in the same cycle must not open the full queue
        bus.mem_resp_valid = 1'b1;
        #1;
        check("no_bypass_issue_ready", bus.issue_ready, 0);
        bus.issue_valid = 1'b0;
        // drain back-to-back, the second one with a bus error
        respond(32'h1111_1111, 1'b0, 1'b0, 1'b0, 4'h0);
        respond(32'hBAD0_BAD0, 1'b1, 1'b0, 1'b0, 4'h0);
        respond(32'h3333_3333, 1'b0, 1'b0, 1'b0, 4'h0);
        respond(32'h4444_4444, 1'b0, 1'b0, 1'b0, 4'h0);

        // accept and pop in the same cycle, slot index 0xF wrapping to 0x0
        issue(32'h0000_2000, 1'b0, 4'hE);
        issue(32'h0000_2004, 1'b0, 4'hF);
        respond(32'hA5A5_A5A5, 1'b0, 1'b1, 1'b1, 4'h0);
        respond(32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0, 4'h0);
        respond(32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 4'h0);

        // response with nothing outstanding
        respond(32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 4'h0);

        // asynchronous reset with three loads outstanding
        issue(32'h0000_3000, 1'b0, 4'h7);
        issue(32'h0000_3004, 1'b1, 4'h8);
        issue(32'h0000_3008, 1'b0, 4'h9);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pending", bus.pending, 0);
        check("async_rst_spurious", bus.spurious_resp, 0);
        check("async_rst_cv_value", bus.cv_value, 0);
        exp_q.delete();
        exp_pending = 0;
        last_conv   = 1'b0;
        last_slot   = '0;
        last_val    = '0;
        last_fault  = F_NONE;
        step();
        reset = 1'b1;
        step();

`ifdef LOAD_TIMEOUT_EN
        // the head times out 64 cycles after its acceptance
        begin
            int waited;
            waited = 0;
            issue(32'h0000_4000, 1'b0, 4'h5);
            issue(32'h0000_4004, 1'b1, 4'h6);
            while (bus.cv_write !== 1'b1 && waited < 100) begin
                step();
                waited++;
            end
            // The first load was accepted one cycle before the loop starts.
            check("timeout_latency", waited, 63);
            check("timeout_slot", bus.cv_slot, 4'h5);
            check("timeout_conveyor", bus.cv_conveyor, 0);
            check("timeout_value", bus.cv_value, 0);
            check("timeout_fault", bus.cv_fault, F_TIMEOUT);
            check("timeout_pending", bus.pending, 1);
            void'(exp_q.pop_front());
            exp_pending--;
            // the late answer to the timed-out load is dropped silently
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'h7777_7777;
            step();
            bus.mem_resp_valid = 1'b0;
            check("drop_no_write", bus.cv_write, 0);
            check("drop_pending", bus.pending, 1);
            check("drop_not_spurious", bus.spurious_resp, 0);
            respond(32'h0000_1234, 1'b0, 1'b0, 1'b0, 4'h0);
        end
`endif

        // outstanding loads discarded by reset: a later response is spurious
        respond(32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0, 4'h0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
